// File: rtl/jpeg_bit_packer.sv
// Packs right-aligned variable-length codewords MSB-first into a byte stream,
// inserts a 0x00 after every 0xFF, and pads the tail with 1s on flush.
module jpeg_bit_packer #(
  parameter int ACC_W = 64,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      code_in,
  input  logic [5:0]       len_in,
  input  logic             flush,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flush_done,
  output logic [CNT_W-1:0] byte_count
);

  localparam int NB_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {RUN, PAD, DRAIN} state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_base, acc_next, append_bits;
  logic [NB_W-1:0]  nbits, nbits_base, nbits_next;
  logic             stuff_pending, stuff_next;
  logic [7:0]       out_byte_next;
  logic             out_valid_next;
  logic             flush_done_next;
  logic             accept, load_en, extract, drained;
  logic [5:0]       len_sat, add_len;
  logic [2:0]       pad_len;
  logic [31:0]      add_code, add_mask;

  assign in_ready = (state == RUN) && (nbits <= NB_W'(31));
  assign accept   = in_valid && in_ready;
  assign load_en  = !out_valid || out_ready;
  assign extract  = load_en && !stuff_pending && (nbits >= NB_W'(8));
  assign drained  = (nbits == '0) && !stuff_pending && load_en;
  assign len_sat  = (len_in > 6'd32) ? 6'd32 : len_in;
  // Extraction never changes nbits mod 8, so the pad length can use nbits directly.
  assign pad_len  = 3'(4'd8 - {1'b0, nbits[2:0]});

  always_comb begin
    add_len  = 6'd0;
    add_code = 32'hFFFF_FFFF;
    if (accept) begin
      add_len  = len_sat;
      add_code = code_in;
    end else if (state == PAD) begin
      add_len  = {3'b000, pad_len};
    end
  end

  // New bits land directly below whatever survives this cycle's byte extraction.
  always_comb begin
    add_mask    = ~(32'hFFFF_FFFF << add_len);
    acc_base    = extract ? (acc << 8) : acc;
    nbits_base  = extract ? (nbits - NB_W'(8)) : nbits;
    append_bits = ({add_code & add_mask, {(ACC_W-32){1'b0}}} << (6'd32 - add_len)) >> nbits_base;
    acc_next    = acc_base | append_bits;
    nbits_next  = nbits_base + NB_W'(add_len);
  end

  always_comb begin
    out_byte_next  = out_byte;
    out_valid_next = out_valid;
    stuff_next     = stuff_pending;
    if (load_en) begin
      if (stuff_pending) begin
        out_byte_next  = 8'h00;
        out_valid_next = 1'b1;
        stuff_next     = 1'b0;
      end else if (nbits >= NB_W'(8)) begin
        out_byte_next  = acc[ACC_W-1 -: 8];
        out_valid_next = 1'b1;
        stuff_next     = (acc[ACC_W-1 -: 8] == 8'hFF);
      end else begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_comb begin
    state_next      = state;
    flush_done_next = 1'b0;
    case (state)
      RUN:     if (flush) state_next = PAD;
      PAD:     state_next = DRAIN;
      DRAIN: begin
        if (drained) begin
          flush_done_next = 1'b1;
          state_next      = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc           <= '0;
      nbits         <= '0;
      stuff_pending <= 1'b0;
      out_byte      <= 8'h00;
      out_valid     <= 1'b0;
      flush_done    <= 1'b0;
      byte_count    <= '0;
    end else begin
      acc           <= acc_next;
      nbits         <= nbits_next;
      stuff_pending <= stuff_next;
      out_byte      <= out_byte_next;
      out_valid     <= out_valid_next;
      flush_done    <= flush_done_next;
      if (out_valid && out_ready) byte_count <= byte_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Randomised and directed bench for jpeg_bit_packer; expected stream comes
// from a bit-queue model of the packing, stuffing and padding rules.
module tb_jpeg_bit_packer;

  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      code_in = '0;
  logic [5:0]       len_in = '0;
  logic             flush = 1'b0;
  logic [7:0]       out_byte;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             flush_done;
  logic [CNT_W-1:0] byte_count;

  int vectors = 0;
  int miscompares = 0;

  bit         bit_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         exp_total = 0;
  int         fd_count = 0;

  jpeg_bit_packer #(.ACC_W(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .code_in(code_in), .len_in(len_in), .flush(flush), .out_byte(out_byte),
    .out_valid(out_valid), .out_ready(out_ready), .flush_done(flush_done),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Model: every whole byte of the bit stream is expected, with 0x00 after 0xFF.
  task automatic model_drain_bytes();
    logic [7:0] b;
    while (bit_q.size() >= 8) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], 1'(bit_q.pop_front())};
      exp_q.push_back(b);
      exp_total++;
      if (b == 8'hFF) begin
        exp_q.push_back(8'h00);
        exp_total++;
      end
    end
  endtask

  // Inputs change #1 after posedge, so the negedge sees what the next edge will take.
  always @(negedge clk) begin
    if (reset) begin
      if (in_valid && in_ready) begin
        int n;
        n = (len_in > 6'd32) ? 32 : int'(len_in);
        for (int i = n - 1; i >= 0; i--) bit_q.push_back(code_in[i]);
        model_drain_bytes();
      end
      if (flush) begin
        while (bit_q.size() % 8 != 0) bit_q.push_back(1'b1);
        model_drain_bytes();
      end
      if (out_valid && out_ready) rx_q.push_back(out_byte);
      if (flush_done) fd_count++;
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    bit_q.delete(); exp_q.delete(); rx_q.delete();
    exp_total = 0;
    fd_count = 0;
  endtask

  task automatic apply_stimulus(input logic [31:0] code, input logic [5:0] len);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    code_in = code;
    len_in = len;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: in_ready never rose for code %h", code);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_flush(input int max_cycles);
    for (int i = 0; i < max_cycles && fd_count == 0; i++) @(negedge clk);
    @(posedge clk); #1;
    vectors++;
    if (fd_count == 0) begin
      miscompares++;
      $display("[TB] FAIL flush_timeout: flush_done not seen in %0d cycles", max_cycles);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out_byte !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_out_byte: got %h expected 00", out_byte); end
    vectors++; if (flush_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flush_done: got %b expected 0", flush_done); end
    vectors++; if (byte_count !== '0) begin miscompares++; $display("[TB] FAIL reset_byte_count: got %0d expected 0", byte_count); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; code_in = 32'hAB; len_in = 6'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_early_valid: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_latency: got %b expected 1", out_valid); end
    vectors++; if (out_byte !== 8'hAB) begin miscompares++; $display("[TB] FAIL single_byte: got %h expected ab", out_byte); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (byte_count !== CNT_W'(1)) begin miscompares++; $display("[TB] FAIL single_count: got %0d expected 1", byte_count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_valid_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_stuff();
    do_reset();
    out_ready = 1'b1;
    apply_stimulus(32'hFF, 6'd8);
    apply_stimulus(32'h12, 6'd8);
    repeat (10) @(posedge clk); #1;
    vectors++; if (rx_q.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL stuff_len: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (rx_q[i] !== exp_q[i]) begin miscompares++; $display("[TB] FAIL stuff_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    vectors++; if (byte_count !== CNT_W'(exp_total)) begin miscompares++; $display("[TB] FAIL stuff_count: got %0d expected %0d", byte_count, exp_total); end
  endtask

  task automatic test_pad();
    do_reset();
    out_ready = 1'b1;
    apply_stimulus(32'b101, 6'd3);
    apply_stimulus(32'b11, 6'd2);
    apply_stimulus(32'b0, 6'd1);
    pulse_flush();
    wait_flush(50);
    repeat (5) @(posedge clk); #1;
    vectors++; if (rx_q.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL pad_len: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (rx_q[i] !== exp_q[i]) begin miscompares++; $display("[TB] FAIL pad_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    vectors++; if (fd_count != 1) begin miscompares++; $display("[TB] FAIL pad_done_pulses: got %0d expected 1", fd_count); end
    vectors++; if (byte_count !== CNT_W'(exp_total)) begin miscompares++; $display("[TB] FAIL pad_count: got %0d expected %0d", byte_count, exp_total); end
  endtask

  task automatic test_pad_ff();
    int rx_at_done;
    do_reset();
    out_ready = 1'b1;
    apply_stimulus(32'h7F, 6'd7);
    pulse_flush();
    rx_at_done = -1;
    for (int i = 0; i < 50 && fd_count == 0; i++) @(negedge clk);
    if (fd_count != 0) rx_at_done = rx_q.size();
    vectors++; if (rx_at_done != exp_q.size()) begin miscompares++; $display("[TB] FAIL padff_done_timing: bytes at done %0d expected %0d", rx_at_done, exp_q.size()); end
    repeat (5) @(posedge clk); #1;
    vectors++; if (rx_q.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL padff_len: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (rx_q[i] !== exp_q[i]) begin miscompares++; $display("[TB] FAIL padff_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    vectors++; if (fd_count != 1) begin miscompares++; $display("[TB] FAIL padff_done_pulses: got %0d expected 1", fd_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] codes[6];
    int idx;
    bit hs;
    codes = '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h0BADF00D, 32'hCAFEBABE, 32'h13579BDF};
    do_reset();
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1; code_in = codes[0]; len_in = 6'd32;
    // Only one byte in the output register plus 56 held bits fit: two codes.
    repeat (12) begin
      @(negedge clk); hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin idx++; code_in = codes[idx]; end
    end
    vectors++; if (idx != 2) begin miscompares++; $display("[TB] FAIL bp_accepted: got %0d codes expected 2", idx); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready); end
    vectors++; if (rx_q.size() != 0) begin miscompares++; $display("[TB] FAIL bp_leak: got %0d bytes expected 0", rx_q.size()); end
    out_ready = 1'b1;
    for (int i = 0; i < 100 && idx < 6; i++) begin
      @(negedge clk); hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin idx++; if (idx < 6) code_in = codes[idx]; end
    end
    in_valid = 1'b0;
    repeat (40) @(posedge clk); #1;
    vectors++; if (rx_q.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL bp_len: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (rx_q[i] !== exp_q[i]) begin miscompares++; $display("[TB] FAIL bp_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    vectors++; if (byte_count !== CNT_W'(exp_total)) begin miscompares++; $display("[TB] FAIL bp_count: got %0d expected %0d", byte_count, exp_total); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    apply_stimulus(32'b101, 6'd3);
    do_reset();
    out_ready = 1'b1;
    pulse_flush();
    wait_flush(50);
    repeat (5) @(posedge clk); #1;
    vectors++; if (rx_q.size() != 0) begin miscompares++; $display("[TB] FAIL mid_reset_bytes: got %0d bytes expected 0", rx_q.size()); end
    vectors++; if (byte_count !== '0) begin miscompares++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", byte_count); end
    vectors++; if (fd_count != 1) begin miscompares++; $display("[TB] FAIL mid_reset_done: got %0d pulses expected 1", fd_count); end
  endtask

  task automatic test_random();
    bit hs;
    do_reset();
    hs = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_ready = ($urandom_range(3) != 0);
      if (hs || !in_valid) begin
        in_valid = ($urandom_range(4) != 0);
        code_in = $urandom;
        if ($urandom_range(7) == 0) len_in = 6'($urandom_range(63, 33));
        else                       len_in = 6'($urandom_range(32));
        if ($urandom_range(5) == 0) code_in = 32'hFFFF_FFFF;
      end
      @(negedge clk); hs = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    pulse_flush();
    wait_flush(200);
    repeat (5) @(posedge clk); #1;
    vectors++; if (rx_q.size() != exp_q.size()) begin miscompares++; $display("[TB] FAIL rand_len: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (rx_q[i] !== exp_q[i]) begin miscompares++; $display("[TB] FAIL rand_byte[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    vectors++; if (byte_count !== CNT_W'(exp_total)) begin miscompares++; $display("[TB] FAIL rand_count: got %0d expected %0d", byte_count, exp_total); end
    vectors++; if (fd_count != 1) begin miscompares++; $display("[TB] FAIL rand_done: got %0d pulses expected 1", fd_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stuff();
    test_pad();
    test_pad_ff();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
